// File: rtl/move_cmd_gen.sv
// ---------------------------------------------------------------------------
// move_cmd_gen
// Turns the four raw board push-buttons into move commands for the 2048 game
// FSM. Each button is synchronised and debounced, and its press edge is
// detected. One single-cycle, one-hot move pulse is then issued per physical
// press, and only while the game reports that it is waiting for a move.
//
// Ports
//   Clk         system clock (single domain)
//   Reset       synchronous, active-high reset
//   btn_up      raw asynchronous button, active-high
//   btn_down    raw asynchronous button, active-high
//   btn_left    raw asynchronous button, active-high
//   btn_right   raw asynchronous button, active-high
//   game_ready  high while the game FSM accepts a move (its wait state)
//   up          registered one-cycle move pulse
//   down        registered one-cycle move pulse
//   left        registered one-cycle move pulse
//   right       registered one-cycle move pulse
//   pending     registered; high while a latched command awaits game_ready
//
// Internal button vectors are ordered {up, down, left, right}. Bit 3 is up.
// ---------------------------------------------------------------------------
module move_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic game_ready,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // One-hot FSM encoding
    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_ARMED   = 4'b0010;
    localparam logic [3:0] ST_ISSUE   = 4'b0100;
    localparam logic [3:0] ST_RELEASE = 4'b1000;

    // Fixed priority: up > down > left > right. Only the winner survives.
    function automatic logic [3:0] pick_winner(input logic [3:0] r);
        logic [3:0] w;
        if (r[3]) begin
            w = 4'b1000;
        end else if (r[2]) begin
            w = 4'b0100;
        end else if (r[1]) begin
            w = 4'b0010;
        end else if (r[0]) begin
            w = 4'b0001;
        end else begin
            w = 4'b0000;
        end
        return w;
    endfunction

    logic [3:0]       btn_s;
    logic [3:0]       s1_q, s2_q;
    logic [3:0]       db_q, db_d;
    logic [3:0]       db_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       rise_s;
    logic [1:0]       warm_q;
    logic             released_s;
    logic [3:0]       state_q, state_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [3:0]       mv_q;
    logic             pending_q;

    assign btn_s  = {btn_up, btn_down, btn_left, btn_right};
    assign rise_s = db_q & ~db_prev_q;

    // warm_q[1] marks that s2_q holds a genuinely sampled button level and
    // not the cleared reset value. Without it, a button held through reset
    // would look released and then produce a fresh rise.
    assign released_s = warm_q[1] & (db_q == 4'b0000) & (s2_q == 4'b0000);

    // Debounce next state: db follows s2 only after CNT_MAX+1 disagreeing cycles
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Command FSM next state and latched command
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (|rise_s) begin
                    state_d = ST_ARMED;
                    cmd_d   = pick_winner(rise_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (game_ready) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RELEASE;
                cmd_d   = 4'b0000;
            end
            ST_RELEASE: begin
                cmd_d = 4'b0000;
                if (released_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_RELEASE;
                cmd_d   = 4'b0000;
            end
        endcase
    end

    // All state registers. Outputs decode next state, so pulses and pending line up with the FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_q      <= 4'b0000;
            s2_q      <= 4'b0000;
            db_q      <= 4'b0000;
            db_prev_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            warm_q    <= 2'b00;
            state_q   <= ST_RELEASE;
            cmd_q     <= 4'b0000;
            mv_q      <= 4'b0000;
            pending_q <= 1'b0;
        end else begin
            s1_q      <= btn_s;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            warm_q    <= {warm_q[0], 1'b1};
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            mv_q      <= (state_d == ST_ISSUE) ? cmd_q : 4'b0000;
            pending_q <= (state_d == ST_ARMED);
        end
    end

    assign up      = mv_q[3];
    assign down    = mv_q[2];
    assign left    = mv_q[1];
    assign right   = mv_q[0];
    assign pending = pending_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
module tb_move_cmd_gen;

    localparam int D = 4;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic [3:0] exp_mask;
    } vec_t;

    typedef struct {
        logic [3:0] mask;
        int         cyc;
    } ev_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic [3:0] btn = 4'b0000;   // {up, down, left, right}
    logic game_ready = 1'b1;
    logic up, down, left, right, pending;

    int cyc = 0;
    int pend_cnt = 0;
    int checks = 0;
    int failures = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];
    vec_t vecs[9];

    move_cmd_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .game_ready(game_ready),
        .up(up), .down(down), .left(left), .right(right), .pending(pending)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic ev_t make_ev(input logic [3:0] m, input int c);
        ev_t e;
        e.mask = m;
        e.cyc  = c;
        return e;
    endfunction

    // Record every observed move pulse with its cycle, and count pending cycles
    always @(negedge Clk) begin
        if ({up, down, left, right} != 4'b0000) obs_q.push_back(make_ev({up, down, left, right}, cyc));
        if (pending) pend_cnt <= pend_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Match observed pulses against expected ones; returns pulses seen.
    task automatic drain(input string name, output int seen);
        ev_t o, e;
        seen = 0;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s unexpected pulse: got mask %b at cyc %0d, expected none", name, o.mask, o.cyc);
            end else begin
                e = exp_q.pop_front();
                if (o.mask != e.mask || o.cyc != e.cyc) begin
                    failures++;
                    $display("FAIL %s pulse: got mask %b cyc %0d, expected mask %b cyc %0d",
                             name, o.mask, o.cyc, e.mask, e.cyc);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s missing pulse: got none, expected mask %b at cyc %0d", name, e.mask, e.cyc);
        end
    endtask

    initial begin
        int seen;
        int p0;

        vecs[0] = '{btn: 4'b0010, hold: 20, exp_mask: 4'b0010};  // single left press
        vecs[1] = '{btn: 4'b1000, hold: 3,  exp_mask: 4'b0000};  // up glitch
        vecs[2] = '{btn: 4'b0101, hold: 20, exp_mask: 4'b0100};  // down+right together
        vecs[3] = '{btn: 4'b0001, hold: 20, exp_mask: 4'b0001};  // right alone
        vecs[4] = '{btn: 4'b1000, hold: 20, exp_mask: 4'b1000};
        vecs[5] = '{btn: 4'b0100, hold: 15, exp_mask: 4'b0100};
        vecs[6] = '{btn: 4'b1111, hold: 12, exp_mask: 4'b1000};  // all four
        vecs[7] = '{btn: 4'b0011, hold: 12, exp_mask: 4'b0010};  // left+right
        vecs[8] = '{btn: 4'b0100, hold: 2,  exp_mask: 4'b0000};  // down glitch

        // Reset state
        tick(3);
        check("reset_moves", int'({up, down, left, right}), 0);
        check("reset_pending", int'(pending), 0);
        Reset = 1'b0;
        tick(10);

        // Table-driven presses: pulse expected 8 edges after the driving negedge
        for (int i = 0; i < 9; i++) begin
            p0 = pend_cnt;
            btn = vecs[i].btn;
            if (vecs[i].exp_mask != 4'b0000) exp_q.push_back(make_ev(vecs[i].exp_mask, cyc + D + 4));
            tick(vecs[i].hold);
            btn = 4'b0000;
            tick(20);
            drain($sformatf("vec%0d", i), seen);
            check($sformatf("vec%0d_count", i), seen, (vecs[i].exp_mask != 4'b0000) ? 1 : 0);
            check($sformatf("vec%0d_pending", i), pend_cnt - p0, (vecs[i].exp_mask != 4'b0000) ? 1 : 0);
        end

        // Game busy: command held in ARMED until game_ready
        game_ready = 1'b0;
        btn = 4'b1000;
        tick(D + 3);
        for (int k = 0; k < 50; k++) begin
            check("busy_pending", int'(pending), 1);
            check("busy_nomove", int'({up, down, left, right}), 0);
            tick(1);
        end
        game_ready = 1'b1;
        exp_q.push_back(make_ev(4'b1000, cyc + 1));
        tick(2);
        check("busy_pending_after", int'(pending), 0);
        btn = 4'b0000;
        tick(20);
        drain("busy", seen);
        check("busy_count", seen, 1);

        // Bouncy release: one right pulse only, then FSM back in IDLE
        btn = 4'b0001;
        exp_q.push_back(make_ev(4'b0001, cyc + D + 4));
        tick(15);
        for (int k = 0; k < 5; k++) begin
            btn[0] = (k % 2 == 1);
            tick(2);
        end
        btn = 4'b0000;
        tick(20);
        drain("bounce", seen);
        check("bounce_count", seen, 1);
        btn = 4'b0010;
        exp_q.push_back(make_ev(4'b0010, cyc + D + 4));
        tick(10);
        btn = 4'b0000;
        tick(20);
        drain("bounce_idle", seen);
        check("bounce_idle_count", seen, 1);

        // Reset while ARMED with left held: no pulse, even while still held
        game_ready = 1'b0;
        btn = 4'b0010;
        tick(D + 3);
        check("rst_armed_pending", int'(pending), 1);
        tick(3);
        Reset = 1'b1;
        tick(1);
        check("rst_pending_clear", int'(pending), 0);
        Reset = 1'b0;
        game_ready = 1'b1;
        p0 = pend_cnt;
        tick(40);
        drain("rst_hold", seen);
        check("rst_hold_count", seen, 0);
        check("rst_hold_pending", pend_cnt - p0, 0);
        btn = 4'b0000;
        tick(20);
        btn = 4'b0010;
        exp_q.push_back(make_ev(4'b0010, cyc + D + 4));
        tick(12);
        btn = 4'b0000;
        tick(20);
        drain("rst_repress", seen);
        check("rst_repress_count", seen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
